uart_rx_word: RTL and testbench
===============================

# uart_rx_word

Serial receiver that is the far-end counterpart of the bus UART word transmitter. It recovers one 16-bit word from two back-to-back 8-bit UART frames (low byte first, LSB first, one start bit, at least one stop bit) and presents the word on a valid/ready interface. It sits between the bus bridge's serial input pin and the slave-side request decoder, and shares that bridge's `clk` and `clken` tick infrastructure.

## Interface
- `OVERSAMPLE`, 16, `clken` ticks per bit period; even, ≥4.
- `TIMEOUT_BITS`, 4, inter-byte gap limit in bit periods; used only when `UART_RX_TIMEOUT_EN` is defined.

- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clken`  in  1  oversample tick, 1-cycle pulse at OVERSAMPLE × baud.
- `rx`  in  1  asynchronous serial input, idle high.
- `data_out`  out  16  received word, {byte1, byte0}.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word when `data_valid && data_ready`.
- `rx_busy`  out  1  high when a frame is in progress or a low byte is held.
- `frame_err`  out  1  1-cycle pulse on a bad stop bit.
- `overrun`  out  1  1-cycle pulse when a completed word is dropped.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. Everything downstream uses `rx_s`.
- The tick counter and all sampling advance only on `clken` cycles. Handshake and flag logic run every `clk`.
- States:
  - IDLE: armed only after `rx_s==1` has been seen since reset or the last framing error. An armed IDLE that sees `rx_s==0` on a tick goes to START with the tick count cleared.
  - START: after OVERSAMPLE/2 ticks, sample `rx_s`. If 0, go to DATA with bit count 0. If 1, treat it as a glitch and return to IDLE still armed.
  - DATA: every OVERSAMPLE ticks, sample and shift into the shift register MSB end, so bit 0 lands first (LSB-first). After 8 samples, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample `rx_s`.
    - If 1 and `byte_sel==0`: store the low byte, set `byte_sel=1`, go to IDLE.
    - If 1 and `byte_sel==1`: complete the word, clear `byte_sel`, go to IDLE.
    - If 0: pulse `frame_err`, discard the partial word, clear `byte_sel`, go to IDLE disarmed.
- Extra stop bits (the transmitter sends two) are ordinary idle time.
- Word completion:
  - If `data_valid==0`, or `data_valid && data_ready` in the same cycle: load `data_out` and hold `data_valid=1`. No overrun.
  - Otherwise: pulse `overrun`. The held word and `data_valid` are unchanged, and the new word is dropped.
- `data_valid` clears in the cycle after the handshake, unless a new word loads in that same cycle.
- `rx_busy = (state != IDLE) || byte_sel`.

## Timing
- Reset values: `data_out=0`, `data_valid=0`, `frame_err=0`, `overrun=0`, `rx_busy=0`. State is IDLE disarmed, `byte_sel=0`, all counters 0.
- Reset mid-frame abandons the frame and any held byte. Reception resumes only after `rx` is seen high.
- `rx` to `rx_s` latency is 2 `clk`.
- `data_valid` rises in the `clk` after the `clken` cycle that samples byte 1's stop bit.
- `frame_err` and `overrun` are high for exactly one `clk` each.
- The sample point is mid-bit, ±1 tick. Baud mismatch tolerated: ≥±3% at OVERSAMPLE=16.
- `clken` asserted on consecutive cycles is legal. `clken` held low freezes the FSM but not the handshake.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - While `byte_sel==1` and in IDLE, count ticks.
  - Reaching TIMEOUT_BITS×OVERSAMPLE ticks without a start bit silently discards the low byte and clears `byte_sel`. No flag is raised.
  - The counter clears on leaving IDLE.
- `UART_RX_TIMEOUT_EN` undefined: the counter is absent, and the held low byte waits indefinitely for byte 1.

## Test plan
- Word 0xA55A at OVERSAMPLE=16 with `data_ready=0` → `data_out=0xA55A` and `data_valid=1`, held. Raise `data_ready` for 1 cycle → `data_valid=0` next cycle.
- Words 0x1234 then 0xBEEF with `data_ready=0` → `data_out` stays 0x1234 and one `overrun` pulse occurs. Repeat with `data_ready` pulsed in the completion cycle → 0xBEEF loads and there is no overrun.
- `rx` low for 3 ticks then high → no reception, `rx_busy` returns to 0, no flags. A following word 0x0001 is received correctly.
- Word with byte 1's stop bit forced 0 → one `frame_err` pulse and no `data_valid`. Then `rx` high for 1 bit and word 0x00FF → `data_out=0x00FF`.
- Timeout enabled: byte 0x11, then 5 idle bit periods, then full word 0xCAFE → `data_out=0xCAFE` and never 0x??11. Timeout disabled: the same stimulus yields 0xFE11.
- `rst` asserted mid-byte 1 of 0x5A5A, then word 0x0F0F → all outputs 0 during reset, then `data_out=0x0F0F`.

Source files
------------

// File: rtl/uart_rx_word.sv
// Two-frame UART receiver that rebuilds a 16-bit word {byte1, byte0} and offers it on valid/ready.
// Optional inter-byte timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_word #(
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        rx,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        rx_busy,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic             rx_meta_q, rx_s_q;
  logic [1:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       low_q, low_d;
  logic             byte_sel_q, byte_sel_d;
  logic             frame_err_q, frame_err_d;
  logic             word_done;
  logic [15:0]      data_q;
  logic             valid_q;
  logic             overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    low_d       = low_q;
    byte_sel_d  = byte_sel_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    if (clken) begin
      case (state_q)
        ST_IDLE: begin
          if (!armed_q) begin
            if (rx_s_q) armed_d = 1'b1;
          end else if (!rx_s_q) begin
            state_d = ST_START;
            tick_d  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d = '0;
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            if (rx_s_q) begin
              if (!byte_sel_q) begin
                low_d      = shift_q;
                byte_sel_d = 1'b1;
              end else begin
                word_done  = 1'b1;
                byte_sel_d = 1'b0;
              end
            end else begin
              // Line may be stuck low or mid-break: wait for idle before hunting for a start bit.
              frame_err_d = 1'b1;
              byte_sel_d  = 1'b0;
              armed_d     = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef UART_RX_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (state_q != ST_IDLE || !byte_sel_q) begin
      to_cnt_d = '0;
    end else if (clken && state_d == ST_IDLE) begin
      if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
        to_cnt_d   = '0;
        byte_sel_d = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      low_q       <= '0;
      byte_sel_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      armed_q     <= armed_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      low_q       <= low_d;
      byte_sel_q  <= byte_sel_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= 1'b0;
      // A finished word may replace the held one only if it is being consumed this cycle.
      if (word_done && (!valid_q || data_ready)) begin
        data_q  <= {shift_q, low_q};
        valid_q <= 1'b1;
      end else begin
        if (valid_q && data_ready) valid_q <= 1'b0;
        if (word_done) overrun_q <= 1'b1;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != ST_IDLE) || byte_sel_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: expected words are queued as frames are sent and
// popped when the bench completes a data_valid/data_ready handshake.
module tb_uart_rx_word;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic        rx = 1'b1;
  logic        data_ready = 1'b0;
  logic [15:0] data_out;
  logic        data_valid, rx_busy, frame_err, overrun;

  int checks = 0;
  int failures = 0;
  int clk_div = 2;
  int div_cnt = 0;
  int fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  logic [15:0] exp_q[$];

  uart_rx_word #(.OVERSAMPLE(OS), .TIMEOUT_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clken      (clken),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      div_cnt = div_cnt + 1;
      if (div_cnt >= clk_div) div_cnt = 0;
      clken = (div_cnt == 0);
    end
  end

  // Flag pulse counters and the scoreboard consumer, sampled between edges.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    #1;
    if (frame_err === 1'b1) begin
      fe_cycles = fe_cycles + 1;
      if (!fe_prev) fe_pulses = fe_pulses + 1;
    end
    fe_prev = (frame_err === 1'b1);
    if (overrun === 1'b1) begin
      ov_cycles = ov_cycles + 1;
      if (!ov_prev) ov_pulses = ov_pulses + 1;
    end
    ov_prev = (overrun === 1'b1);
    if (data_valid === 1'b1 && data_ready === 1'b1) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_unexpected: got word %h, expected no word", data_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (data_out !== exp_w) begin
          failures = failures + 1;
          $display("FAIL scoreboard_word: got %h, expected %h", data_out, exp_w);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    int bc;
    bc = OS * clk_div;
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (bc) @(negedge clk);
    rx = 1'b1;
    repeat (bc) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * OS * clk_div) @(negedge clk);
  endtask

  // Waits for a word, consumes it with a 1-cycle ready pulse, and checks valid drops next cycle.
  task automatic accept_word(input string name, input int budget);
    int n;
    n = 0;
    while (data_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks = checks + 1;
    if (data_valid !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL %s_valid_timeout: data_valid=%b, expected 1 within %0d cycles", name, data_valid, budget);
      return;
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    #1;
    checks = checks + 1;
    if (data_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL %s_valid_clear: data_valid=%b after handshake, expected 0", name, data_valid);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks = checks + 1;
    if ({data_out, data_valid, rx_busy, frame_err, overrun} !== 20'h0) begin
      failures = failures + 1;
      $display("FAIL %s: data_out=%h valid=%b busy=%b fe=%b ov=%b, expected all 0",
               name, data_out, data_valid, rx_busy, frame_err, overrun);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    exp_q.push_back(16'hA55A);
    send_word(16'hA55A);
    repeat (40) @(negedge clk);
    checks = checks + 1;
    if (data_valid !== 1'b1 || data_out !== 16'hA55A) begin
      failures = failures + 1;
      $display("FAIL basic_hold: valid=%b data_out=%h, expected 1 a55a", data_valid, data_out);
    end
    accept_word("basic", 200);
  endtask

  task automatic test_overrun();
    int ov0, ovc0;
    ov0 = ov_pulses; ovc0 = ov_cycles;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    send_word(16'hBEEF);
    repeat (10) @(negedge clk);
    checks = checks + 1;
    if (ov_pulses - ov0 != 1 || ov_cycles - ovc0 != 1) begin
      failures = failures + 1;
      $display("FAIL overrun_pulse: pulses=%0d cycles=%0d, expected 1 1", ov_pulses - ov0, ov_cycles - ovc0);
    end
    checks = checks + 1;
    if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
      failures = failures + 1;
      $display("FAIL overrun_held: valid=%b data_out=%h, expected 1 1234", data_valid, data_out);
    end
    accept_word("overrun_first", 200);

    // Consecutive clken: byte 1's stop bit is sampled 154 cycles after its start edge is driven.
    clk_div = 1;
    repeat (20) @(negedge clk);
    ov0 = ov_pulses;
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    exp_q.push_back(16'hBEEF);
    send_byte(8'hEF, 1'b0);
    fork
      send_byte(8'hBE, 1'b0);
      begin
        repeat (154) @(negedge clk);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
      end
    join
    checks = checks + 1;
    if (ov_pulses != ov0) begin
      failures = failures + 1;
      $display("FAIL overrun_simul: overrun pulses=%0d, expected 0", ov_pulses - ov0);
    end
    checks = checks + 1;
    if (data_valid !== 1'b1 || data_out !== 16'hBEEF || exp_q.size() != 1) begin
      failures = failures + 1;
      $display("FAIL overrun_simul_load: valid=%b data_out=%h pending=%0d, expected 1 beef 1",
               data_valid, data_out, exp_q.size());
    end
    accept_word("overrun_simul", 200);
    clk_div = 2;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_pulses; ov0 = ov_pulses;
    rx = 1'b0;
    repeat (3 * clk_div) @(negedge clk);
    rx = 1'b1;
    repeat (2 * OS * clk_div) @(negedge clk);
    checks = checks + 1;
    if (rx_busy !== 1'b0 || data_valid !== 1'b0 || fe_pulses != fe0 || ov_pulses != ov0) begin
      failures = failures + 1;
      $display("FAIL glitch: busy=%b valid=%b fe=%0d ov=%0d, expected 0 0 0 0",
               rx_busy, data_valid, fe_pulses - fe0, ov_pulses - ov0);
    end
    exp_q.push_back(16'h0001);
    send_word(16'h0001);
    accept_word("glitch_next", 200);
  endtask

  task automatic test_frame_err();
    int fe0, fec0;
    fe0 = fe_pulses; fec0 = fe_cycles;
    send_byte(8'hC3, 1'b0);
    send_byte(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    checks = checks + 1;
    if (fe_pulses - fe0 != 1 || fe_cycles - fec0 != 1) begin
      failures = failures + 1;
      $display("FAIL frame_err_pulse: pulses=%0d cycles=%0d, expected 1 1", fe_pulses - fe0, fe_cycles - fec0);
    end
    checks = checks + 1;
    if (data_valid !== 1'b0 || rx_busy !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL frame_err_discard: valid=%b busy=%b, expected 0 0", data_valid, rx_busy);
    end
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF);
    accept_word("frame_err_next", 200);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h5A, 1'b0);
    fork
      send_byte(8'h5A, 1'b0);
      begin
        repeat (4 * OS * clk_div) @(negedge clk);
        rst = 1'b1;
      end
    join
    check_outputs_zero("reset_mid_outputs");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(16'h0F0F);
    send_word(16'h0F0F);
    accept_word("reset_mid_next", 200);
  endtask

  task automatic test_timeout();
    logic exp_busy;
    send_byte(8'h11, 1'b0);
    idle_bits(5);
`ifdef UART_RX_TIMEOUT_EN
    exp_q.push_back(16'hCAFE);
    exp_busy = 1'b0;
`else
    exp_q.push_back(16'hFE11);
    exp_busy = 1'b1;
`endif
    send_word(16'hCAFE);
    accept_word("timeout", 200);
    checks = checks + 1;
    if (rx_busy !== exp_busy) begin
      failures = failures + 1;
      $display("FAIL timeout_busy: rx_busy=%b, expected %b", rx_busy, exp_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_timeout();
    repeat (10) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d words pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
